stereo_core_sequencer: RTL
==========================

# stereo_core_sequencer

Frame-level controller that shares one mono audio processing core between the left and right channels of a stereo stream. It accepts a stereo frame, issues the left sample and then the right sample to the core over a valid/ready channel, and collects the two core results in order. It then presents the processed stereo frame downstream. It sits between the stereo input stage and the stereo output stage of the echo path, in place of two duplicated mono cores.

## Interface
Parameters:
- audio_width, default 32, sample width for all audio buses.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  input stereo frame valid.
- i_ready  output  1  sequencer can accept a frame.
- i_left  input  audio_width  input left sample.
- i_right  input  audio_width  input right sample.
- i_bypass  input  1  when high at frame acceptance, the frame skips the core.
- c_valid  output  1  sample to core valid.
- c_ready  input  1  core accepts sample.
- c_is_left  output  1  the current core sample is left (1) or right (0).
- c_audio  output  audio_width  sample to core.
- r_valid  input  1  core result valid.
- r_ready  output  1  sequencer accepts core result.
- r_audio  input  audio_width  core result.
- o_valid  output  1  output stereo frame valid.
- o_ready  input  1  downstream accepts frame.
- o_left  output  audio_width  output left sample.
- o_right  output  audio_width  output right sample.
- o_frames  output  16  count of completed output handshakes.

## Operation
- States: IDLE, SEND_L, RECV_L, SEND_R, RECV_R, OUT. Encoding is free.
- Control outputs are decoded from state:
  - i_ready = (IDLE).
  - c_valid = (SEND_L or SEND_R).
  - c_is_left = 1 in SEND_L and RECV_L, 0 in SEND_R and RECV_R, 1 otherwise.
  - r_ready = (RECV_L or RECV_R).
  - o_valid = (OUT).
- c_audio is the registered left input in SEND_L and RECV_L, and the registered right input otherwise.
- IDLE:
  - On i_valid && i_ready, register i_left and i_right, and sample i_bypass.
  - If bypass: load o_left = i_left and o_right = i_right, then go to OUT.
  - Otherwise go to SEND_L.
- SEND_L: on c_valid && c_ready, go to RECV_L.
- RECV_L: on r_valid && r_ready, o_left <= r_audio, then go to SEND_R.
- SEND_R: on c_valid && c_ready, go to RECV_R.
- RECV_R: on r_valid && r_ready, o_right <= r_audio, then go to OUT.
- OUT: on o_valid && o_ready, o_frames <= o_frames + 1 (mod 2^16, 0xFFFF wraps to 0x0000), then go to IDLE.
- Strict ordering:
  - At most one sample is outstanding at the core.
  - The core must return results in issue order.
  - A core result offered outside RECV_L or RECV_R is not taken (r_ready = 0); the core holds it.
- i_bypass is ignored except in the acceptance cycle. Toggling it mid-frame has no effect on that frame.
- Held data (the registered inputs, o_left, o_right) must not change between handshakes, except as specified above.
- No arithmetic on samples; data are passed through bit-exact.

## Timing
- Reset values while reset_n = 0 and after it rises:
  - State IDLE.
  - i_ready = 1, c_valid = 0, c_is_left = 1, r_ready = 0, o_valid = 0.
  - c_audio = 0, o_left = 0, o_right = 0, o_frames = 0.
- Reset assertion mid-frame abandons the frame immediately: outputs go to their reset values asynchronously and no partial frame is emitted. The core must be reset with the sequencer.
- Processed frame with zero-wait core and downstream:
  - Acceptance edge at cycle 0.
  - SEND_L in cycle 1, RECV_L in 2, SEND_R in 3, RECV_R in 4.
  - o_valid is high in cycle 5.
  - i_ready returns in cycle 6.
  - Throughput: 1 frame per 6 cycles.
- Bypass frame: o_valid is high in cycle 1, i_ready in cycle 2. Throughput: 1 frame per 2 cycles.
- Each stall cycle (c_ready = 0, r_valid = 0, or o_ready = 0) extends its state by exactly one cycle.
- There is no combinational path from any input to any output except through the state-decoded signals. i_ready does not depend on o_ready.

## Test plan
- Processed frame: i_left = 0x11111111, i_right = 0x22222222, core returns the sample XOR 0xFFFFFFFF with 0 latency, o_ready = 1 -> c_audio shows 0x11111111 (c_is_left = 1) then 0x22222222 (c_is_left = 0). Output is o_left = 0xEEEEEEEE, o_right = 0xDDDDDDDD, o_valid high exactly cycle 5, o_frames = 1.
- Bypass: i_bypass = 1 with left = 0xA5, right = 0x5A -> c_valid never asserts, o_valid in cycle 1 with o_left = 0xA5, o_right = 0x5A. Deasserting i_bypass during OUT has no effect.
- Backpressure: c_ready low 3 cycles in SEND_L, r_valid delayed 4 cycles in RECV_R, o_ready low 2 cycles in OUT -> o_valid appears in cycle 12 and stays high with stable data until the handshake. i_ready stays 0 throughout.
- Early core result: core asserts r_valid during SEND_R -> r_ready = 0, result not consumed until RECV_R, frame data correct.
- Counter wrap: 65537 frames -> o_frames reads 0xFFFF after 65535, 0x0000 after 65536, 0x0001 after 65537.
- Reset mid-frame: drop reset_n in RECV_R -> all outputs reach reset values without a clock edge. After release, the next frame is processed correctly and o_frames restarts from 0.

Source files
------------

// File: rtl/stereo_core_sequencer.sv
// stereo_core_sequencer: time-shares one mono core between the left and right channels,
// issuing left then right and collecting results in order before presenting the stereo frame.
module stereo_core_sequencer #(
    parameter int audio_width = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [audio_width-1:0] i_left,
    input  logic [audio_width-1:0] i_right,
    input  logic                   i_bypass,
    output logic                   c_valid,
    input  logic                   c_ready,
    output logic                   c_is_left,
    output logic [audio_width-1:0] c_audio,
    input  logic                   r_valid,
    output logic                   r_ready,
    input  logic [audio_width-1:0] r_audio,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [audio_width-1:0] o_left,
    output logic [audio_width-1:0] o_right,
    output logic [15:0]            o_frames
);
    typedef enum logic [2:0] {IDLE, SEND_L, RECV_L, SEND_R, RECV_R, OUT} state_t;
    state_t state;
    logic [audio_width-1:0] left_q, right_q;
    // Handshake controls depend only on the state register, never on inputs
    assign i_ready   = state == IDLE;
    assign c_valid   = state == SEND_L || state == SEND_R;
    assign c_is_left = !(state == SEND_R || state == RECV_R);
    assign r_ready   = state == RECV_L || state == RECV_R;
    assign o_valid   = state == OUT;
    assign c_audio   = (state == SEND_L || state == RECV_L) ? left_q : right_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            left_q   <= '0;
            right_q  <= '0;
            o_left   <= '0;
            o_right  <= '0;
            o_frames <= '0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    left_q  <= i_left;
                    right_q <= i_right;
                    if (i_bypass) begin
                        o_left  <= i_left;
                        o_right <= i_right;
                        state   <= OUT;
                    end else begin
                        state <= SEND_L;
                    end
                end
                SEND_L: if (c_ready) state <= RECV_L;
                RECV_L: if (r_valid) begin
                    o_left <= r_audio;
                    state  <= SEND_R;
                end
                SEND_R: if (c_ready) state <= RECV_R;
                RECV_R: if (r_valid) begin
                    o_right <= r_audio;
                    state   <= OUT;
                end
                OUT: if (o_ready) begin
                    o_frames <= o_frames + 16'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
